imem_loader: RTL and testbench
==============================

# imem_loader

Program loader that writes the instruction memory read by the fetch stage. It accepts a byte stream over a valid/ready handshake and packs each group of four bytes little-endian into a 32-bit instruction word. Each word is written to sequential word-aligned byte addresses starting at 0. While a load session runs it asserts `hold` so the fetch stage's PC register does not advance.

## Interface
Parameters:
- `WORDS`, 256, instruction memory depth in words.
- `ADDR_SIZE`, 64, width of the byte address driven on `wr_addr`.
- `SIZE`, 32, bits per instruction word.
- `CNT_W`, 9, width of `word_count`; must hold the value `WORDS`.

Ports:
- `clock`  in  1  single clock; all state changes on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle request to begin a session; sampled only in IDLE.
- `word_count`  in  CNT_W  number of words to load; sampled with `start`.
- `in_byte`  in  8  stream byte.
- `in_valid`  in  1  `in_byte` is valid.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `wr_en`  out  1  instruction-memory write strobe, one cycle per word.
- `wr_addr`  out  ADDR_SIZE  byte address of the write; always a multiple of 4.
- `wr_data`  out  SIZE  instruction word to write.
- `hold`  out  1  stall request to the fetch stage.
- `busy`  out  1  session in progress.
- `done`  out  1  one-cycle pulse when a session completes.
- `error`  out  1  sticky flag for a rejected `word_count`.

## Operation
States are IDLE, RECV, WRITE and DONE. `busy` and `hold` are 1 in every state other than IDLE.

IDLE:
- `in_ready` = 0 and `wr_en` = 0.
- `start` with `word_count` > `WORDS`: set `error` = 1 and stay in IDLE.
- `start` with `word_count` = 0: clear `error` and go to DONE; no writes occur.
- Any other `start`: clear `error`, latch the count, and clear the word counter, byte index and `wr_addr`. Go to RECV.

RECV:
- `in_ready` = 1.
- A byte is accepted on every edge where `in_valid && in_ready` is true.
- Byte k of a word (k = 0..3) goes into bits [8k+7:8k] of the word being assembled; the first byte received is the LSB.
- When the 4th byte is accepted: register the assembled word onto `wr_data` and go to WRITE.

WRITE:
- `wr_en` = 1 for exactly this cycle, with `in_ready` = 0.
- On exit: increment the word counter and reset the byte index to 0.
- If the word counter now equals the latched count, go to DONE. Otherwise add 4 to `wr_addr` and go to RECV.

DONE:
- `done` = 1 for this cycle only, then go to IDLE.

Rules that apply in every state:
- `start` outside IDLE is ignored and `word_count` is not resampled.
- `wr_addr` and `wr_data` hold their last values while `wr_en` = 0.
- `wr_addr` never exceeds (`WORDS`-1)*4 because the count check guarantees it.
- Async reset in any state forces IDLE and every output to its reset value. A partially assembled word is discarded. Words already written remain in memory.

## Timing
- Reset values: `in_ready`, `wr_en`, `hold`, `busy`, `done` and `error` are 0; `wr_addr` and `wr_data` are all zeros.
- `hold` and `busy` rise on the edge after a `start` is accepted. They fall on the edge after the DONE cycle.
- With `in_valid` held high, each word takes 5 cycles: 4 accept cycles followed by 1 write cycle.
- `wr_en` is asserted in the cycle after the edge that accepts the 4th byte.
- `done` is asserted in the cycle after the final WRITE cycle.
- `in_ready` is 0 during WRITE, so a stalled byte stays pending and is accepted in the next RECV cycle.
- For `word_count` = 0, `done` is asserted 1 cycle after `start`.

## Test plan
- Reset: assert `reset_n` = 0 at any time → all outputs 0 and state is IDLE; `start` is ignored while reset is held.
- Two-word load:
  - Stimulus: `word_count` = 2; bytes 13 00 80 D2 then 20 00 80 D2 with `in_valid` held high.
  - Required: `wr_en` pulses with (addr 0x0, data 0xD2800013) and then (addr 0x4, data 0xD2800020), 5 cycles apart.
  - Required: `done` pulses 1 cycle after the second write; `hold` falls on the following edge.
- Backpressure: same bytes with `in_valid` toggled randomly → same two writes and data; `in_ready` is 0 during each WRITE cycle.
- Zero count: `start` with `word_count` = 0 → `done` 1 cycle later, no `wr_en`, `hold` high for exactly 1 cycle.
- Bad count:
  - Stimulus: `start` with `word_count` = 257.
  - Required: `error` = 1 and `hold` stays 0.
  - Follow-up: a `start` with `word_count` = 1 clears `error` and the word writes at addr 0.
- Reset mid-word: drop `reset_n` after 2 bytes of a word are accepted → outputs reset; a new session writes its first word at addr 0 and the stale bytes are not included in it.

Source files
------------

// File: rtl/imem_loader.sv
// Instruction-memory program loader: packs a little-endian byte stream into
// 32-bit words and writes them to consecutive word addresses while holding fetch.
module imem_loader #(
    parameter int WORDS     = 256,
    parameter int ADDR_SIZE = 64,
    parameter int SIZE      = 32,
    parameter int CNT_W     = 9
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [CNT_W-1:0]     word_count,
    input  logic [7:0]           in_byte,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 wr_en,
    output logic [ADDR_SIZE-1:0] wr_addr,
    output logic [SIZE-1:0]      wr_data,
    output logic                 hold,
    output logic                 busy,
    output logic                 done,
    output logic                 error
);

    localparam int BYTES = SIZE / 8;
    localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [CNT_W-1:0] WORDS_C  = CNT_W'(WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [CNT_W-1:0]     word_cnt_q, word_cnt_d;
    logic [IDX_W-1:0]     byte_idx_q, byte_idx_d;
    logic [SIZE-1:0]      asm_q, asm_d;
    logic [ADDR_SIZE-1:0] wr_addr_q, wr_addr_d;
    logic [SIZE-1:0]      wr_data_q, wr_data_d;
    logic                 error_q, error_d;
    logic [CNT_W-1:0]     word_cnt_inc;
    logic [SIZE-1:0]      asm_next;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            count_q    <= '0;
            word_cnt_q <= '0;
            byte_idx_q <= '0;
            asm_q      <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            word_cnt_q <= word_cnt_d;
            byte_idx_q <= byte_idx_d;
            asm_q      <= asm_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            error_q    <= error_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        word_cnt_d   = word_cnt_q;
        byte_idx_d   = byte_idx_q;
        asm_d        = asm_q;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        error_d      = error_q;
        word_cnt_inc = word_cnt_q + CNT_W'(1);
        asm_next     = asm_q;
        asm_next[byte_idx_q*8 +: 8] = in_byte;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (word_count > WORDS_C) begin
                        error_d = 1'b1;
                    end else if (word_count == '0) begin
                        error_d = 1'b0;
                        state_d = DONE;
                    end else begin
                        error_d    = 1'b0;
                        count_d    = word_count;
                        word_cnt_d = '0;
                        byte_idx_d = '0;
                        wr_addr_d  = '0;
                        state_d    = RECV;
                    end
                end
            end
            RECV: begin
                if (in_valid) begin
                    asm_d      = asm_next;
                    byte_idx_d = byte_idx_q + IDX_W'(1);
                    if (byte_idx_q == LAST_IDX) begin
                        wr_data_d = asm_next;
                        state_d   = WRITE;
                    end
                end
            end
            WRITE: begin
                word_cnt_d = word_cnt_inc;
                byte_idx_d = '0;
                if (word_cnt_inc == count_q) begin
                    state_d = DONE;
                end else begin
                    wr_addr_d = wr_addr_q + ADDR_SIZE'(4);
                    state_d   = RECV;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // All handshake/status outputs decode directly from the registered state.
    assign in_ready = (state_q == RECV);
    assign wr_en    = (state_q == WRITE);
    assign done     = (state_q == DONE);
    assign busy     = (state_q != IDLE);
    assign hold     = (state_q != IDLE);
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign error    = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: vector table for the main flow plus
// hand-written sequences for backpressure and reset during a word.
module tb_imem_loader;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic [8:0]  word_count;
    logic [7:0]  in_byte;
    logic        in_valid;
    logic        in_ready;
    logic        wr_en;
    logic [63:0] wr_addr;
    logic [31:0] wr_data;
    logic        hold;
    logic        busy;
    logic        done;
    logic        error;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clock = ~clock;

    imem_loader #(.WORDS(256), .ADDR_SIZE(64), .SIZE(32), .CNT_W(9)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (start),
        .word_count (word_count),
        .in_byte    (in_byte),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .hold       (hold),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    // flags = {in_ready, wr_en, hold, busy, done, error}
    localparam logic [5:0] F_IDLE  = 6'b000000;
    localparam logic [5:0] F_ERR   = 6'b000001;
    localparam logic [5:0] F_RECV  = 6'b101100;
    localparam logic [5:0] F_WRITE = 6'b011100;
    localparam logic [5:0] F_DONE  = 6'b001110;

    typedef struct {
        logic        st;
        logic [8:0]  wc;
        logic [7:0]  b;
        logic        v;
        logic [5:0]  flags;
        logic [63:0] addr;
        logic [31:0] data;
    } vec_t;

    vec_t vq[$];

    function automatic logic [5:0] flags_now();
        return {in_ready, wr_en, hold, busy, done, error};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic add(input logic st, input logic [8:0] wc, input logic [7:0] b, input logic v,
                       input logic [5:0] fl, input logic [63:0] a, input logic [31:0] d);
        vec_t t;
        t.st = st; t.wc = wc; t.b = b; t.v = v; t.flags = fl; t.addr = a; t.data = d;
        vq.push_back(t);
    endtask

    logic [7:0]  bp_bytes [8];
    logic [63:0] wa_log [2];
    logic [31:0] wd_log [2];

    initial begin
        int nwr;
        int idx;
        int cyc;
        logic rdy;

        reset_n = 1'b0; start = 1'b1; word_count = 9'd1; in_byte = 8'h00; in_valid = 1'b0;

        // Reset held across edges with start asserted: must stay idle.
        tick(); tick();
        check("reset_flags", 64'(flags_now()), 64'(F_IDLE));
        check("reset_addr", wr_addr, 64'h0);
        check("reset_data", 64'(wr_data), 64'h0);
        start = 1'b0;
        reset_n = 1'b1;
        tick();

        // Two-word load, zero count, bad count, recovery.
        add(1, 9'd2,   8'h00, 0, F_RECV,  64'h0, 32'h0);
        add(0, 9'd0,   8'h13, 1, F_RECV,  64'h0, 32'h0);
        add(1, 9'd1,   8'h00, 1, F_RECV,  64'h0, 32'h0);
        add(0, 9'd0,   8'h80, 1, F_RECV,  64'h0, 32'h0);
        add(0, 9'd0,   8'hD2, 1, F_WRITE, 64'h0, 32'hD2800013);
        add(0, 9'd0,   8'h20, 1, F_RECV,  64'h4, 32'hD2800013);
        add(0, 9'd0,   8'h20, 1, F_RECV,  64'h4, 32'hD2800013);
        add(0, 9'd0,   8'h00, 1, F_RECV,  64'h4, 32'hD2800013);
        add(0, 9'd0,   8'h80, 1, F_RECV,  64'h4, 32'hD2800013);
        add(0, 9'd0,   8'hD2, 1, F_WRITE, 64'h4, 32'hD2800020);
        add(0, 9'd0,   8'h00, 0, F_DONE,  64'h4, 32'hD2800020);
        add(0, 9'd0,   8'h00, 0, F_IDLE,  64'h4, 32'hD2800020);
        add(1, 9'd0,   8'h00, 0, F_DONE,  64'h4, 32'hD2800020);
        add(0, 9'd0,   8'h00, 0, F_IDLE,  64'h4, 32'hD2800020);
        add(1, 9'd257, 8'h00, 0, F_ERR,   64'h4, 32'hD2800020);
        add(0, 9'd0,   8'h00, 0, F_ERR,   64'h4, 32'hD2800020);
        add(1, 9'd1,   8'h00, 0, F_RECV,  64'h0, 32'hD2800020);
        add(0, 9'd0,   8'h78, 1, F_RECV,  64'h0, 32'hD2800020);
        add(0, 9'd0,   8'h56, 1, F_RECV,  64'h0, 32'hD2800020);
        add(0, 9'd0,   8'h34, 1, F_RECV,  64'h0, 32'hD2800020);
        add(0, 9'd0,   8'h12, 1, F_WRITE, 64'h0, 32'h12345678);
        add(0, 9'd0,   8'h00, 0, F_DONE,  64'h0, 32'h12345678);
        add(0, 9'd0,   8'h00, 0, F_IDLE,  64'h0, 32'h12345678);

        for (int i = 0; i < vq.size(); i++) begin
            start = vq[i].st; word_count = vq[i].wc; in_byte = vq[i].b; in_valid = vq[i].v;
            tick();
            check($sformatf("vec%0d_flags", i), 64'(flags_now()), 64'(vq[i].flags));
            check($sformatf("vec%0d_addr", i), wr_addr, vq[i].addr);
            check($sformatf("vec%0d_data", i), 64'(wr_data), 64'(vq[i].data));
        end
        start = 1'b0; in_valid = 1'b0;

        // Backpressure: random in_valid, same two words.
        bp_bytes = '{8'h13, 8'h00, 8'h80, 8'hD2, 8'h20, 8'h00, 8'h80, 8'hD2};
        nwr = 0; idx = 0; cyc = 0;
        start = 1'b1; word_count = 9'd2;
        tick();
        start = 1'b0;
        while (!done && cyc < 300) begin
            rdy = in_ready;
            in_valid = (idx < 8) ? 1'($urandom_range(0, 1)) : 1'b0;
            in_byte = (idx < 8) ? bp_bytes[idx] : 8'h00;
            tick();
            cyc++;
            if (rdy && in_valid) idx++;
            if (wr_en) begin
                check("bp_ready_in_write", 64'(in_ready), 64'h0);
                if (nwr < 2) begin
                    wa_log[nwr] = wr_addr;
                    wd_log[nwr] = wr_data;
                end
                nwr++;
            end
        end
        in_valid = 1'b0;
        check("bp_done_seen", 64'(done), 64'h1);
        check("bp_bytes_taken", 64'(idx), 64'd8);
        check("bp_write_count", 64'(nwr), 64'd2);
        if (nwr == 2) begin
            check("bp_addr0", wa_log[0], 64'h0);
            check("bp_data0", 64'(wd_log[0]), 64'hD2800013);
            check("bp_addr1", wa_log[1], 64'h4);
            check("bp_data1", 64'(wd_log[1]), 64'hD2800020);
        end
        tick();
        check("bp_idle_after", 64'(flags_now()), 64'(F_IDLE));

        // Reset in the middle of the second word.
        start = 1'b1; word_count = 9'd2;
        tick();
        start = 1'b0; in_valid = 1'b1;
        in_byte = 8'h11; tick();
        in_byte = 8'h22; tick();
        in_byte = 8'h33; tick();
        in_byte = 8'h44; tick();
        check("rst_pre_write", 64'(flags_now()), 64'(F_WRITE));
        in_byte = 8'h55; tick();
        in_byte = 8'h55; tick();
        in_byte = 8'h66; tick();
        check("rst_pre_addr", wr_addr, 64'h4);
        in_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_async_flags", 64'(flags_now()), 64'(F_IDLE));
        check("rst_async_addr", wr_addr, 64'h0);
        check("rst_async_data", 64'(wr_data), 64'h0);
        tick();
        reset_n = 1'b1;
        start = 1'b1; word_count = 9'd1;
        tick();
        start = 1'b0; in_valid = 1'b1;
        check("rst_new_recv", 64'(flags_now()), 64'(F_RECV));
        in_byte = 8'hA1; tick();
        in_byte = 8'hB2; tick();
        in_byte = 8'hC3; tick();
        in_byte = 8'hD4; tick();
        in_valid = 1'b0;
        check("rst_new_flags", 64'(flags_now()), 64'(F_WRITE));
        check("rst_new_addr", wr_addr, 64'h0);
        check("rst_new_data", 64'(wr_data), 64'hD4C3B2A1);
        tick();
        check("rst_new_done", 64'(flags_now()), 64'(F_DONE));
        tick();
        check("rst_new_idle", 64'(flags_now()), 64'(F_IDLE));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
